riscv_ex_result: RTL and testbench
==================================

Name: riscv_ex_result

Overview:
- EX-stage result collector. Sits directly downstream of the multiplier, the ALU and the divider.
- Merges their single-cycle result pulses (`*_bubble` low for one cycle) into one registered EX→MEM pipeline output.
- A multi-cycle unit cannot be frozen mid-operation. A 1-entry skid register therefore catches any result that completes while MEM stalls, so no result is lost.
- Generates `ex_stall` back to ID/EX issue logic.

Parameters:
- XLEN, 32, datapath/result width
- SRC_W, 2, width of source-unit tag

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- alu_bubble  input  1  low = alu_r valid this cycle
- alu_r  input  XLEN  ALU result
- mul_bubble  input  1  low = mul_r valid this cycle
- mul_r  input  XLEN  multiplier result
- div_bubble  input  1  low = div_r valid this cycle
- div_r  input  XLEN  divider result
- ex_flush  input  1  kill younger-than-stage results (skid + incoming)
- mem_stall  input  1  downstream cannot accept; stage register must hold
- ex_stall  output  1  mem_stall | skid_valid
- ex_bubble  output  1  low = ex_r valid
- ex_r  output  XLEN  registered result to MEM
- ex_src  output  SRC_W  producer of ex_r: 0=none, 1=ALU, 2=MUL, 3=DIV
- err_multi  output  1  sticky: more than one unit valid in the same cycle
- err_ovf  output  1  sticky: result dropped, skid full

Behaviour:

Reset (rstn low, asynchronous):
- ex_bubble=1, ex_r=0, ex_src=0.
- skid_valid=0, skid data/src=0.
- err_multi=0, err_ovf=0.
- ex_stall follows mem_stall.

Incoming select (combinational):
- in_valid = any *_bubble low.
- Priority MUL > DIV > ALU; lower-priority valid results are discarded.
- If two or more are valid in one cycle: err_multi <= 1, held until reset.

Stage register S (ex_bubble/ex_r/ex_src) and skid register K, evaluated each posedge:
- mem_stall=0, K empty: S <= incoming; S becomes a bubble if !in_valid (ex_r holds last value, ex_src=0). Latency: valid input in cycle N → ex_bubble=0 in cycle N+1.
- mem_stall=0, K full: S <= K. K <= incoming if in_valid, else K empties.
- mem_stall=1: S holds.
  - in_valid and K empty: K <= incoming.
  - in_valid and K full: incoming dropped, err_ovf <= 1 (sticky).
- ex_flush=1: K empties and incoming is discarded in that cycle. S is unaffected and still follows the mem_stall rules. Flush overrides every K load above.
- ex_stall = mem_stall | skid_valid, combinational from a register and an input. Upstream issues nothing new while ex_stall=1. A unit already in flight may still complete.

Other rules:
- No arithmetic; widths pass through unchanged.
- err_* flags are observability only and do not alter the dataflow.

Test Plan:
1. Reset with all bubbles high → ex_bubble=1, ex_r=0, ex_src=0, ex_stall=0, err_*=0. Drop rstn mid-stream while K is full → K cleared, ex_bubble=1 immediately (asynchronous).
2. alu_r=0x11 valid in cycle 0, mul_r=0x22 valid in cycle 1, mem_stall=0 → cycle 1: ex_r=0x11, ex_src=1; cycle 2: ex_r=0x22, ex_src=2; cycle 3: ex_bubble=1.
3. mem_stall=1 cycles 0–3, S holds 0x11; mul_r=0xDEAD valid in cycle 1 → K filled, ex_stall=1 from cycle 2. Release in cycle 4 → cycle 5: ex_r=0xDEAD, ex_src=2, ex_stall=0.
4. K full, mem_stall drops in the same cycle div_r=0x5 arrives → next cycle S=K contents, K=0x5 (ex_src 3 one cycle later), ex_stall stays 1 for that cycle.
5. mem_stall=1, K full, alu_r valid → err_ovf=1, the ALU value never appears, S and K unchanged. Separately, mul and alu valid in the same cycle → ex_r=mul_r, err_multi=1 held.
6. K full, ex_flush=1 together with valid div_r while mem_stall=1 → K empty, div_r discarded, ex_stall falls to mem_stall, S unchanged.

Source files
------------

// File: rtl/riscv_ex_result.sv
// EX-stage result collector: merges ALU/MUL/DIV result pulses into one registered EX->MEM
// output, with a 1-entry skid register that catches results completing while MEM stalls.
module riscv_ex_result #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SRC_W = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alu_bubble,
  input  logic [XLEN-1:0]  alu_r,
  input  logic             mul_bubble,
  input  logic [XLEN-1:0]  mul_r,
  input  logic             div_bubble,
  input  logic [XLEN-1:0]  div_r,
  input  logic             ex_flush,
  input  logic             mem_stall,
  output logic             ex_stall,
  output logic             ex_bubble,
  output logic [XLEN-1:0]  ex_r,
  output logic [SRC_W-1:0] ex_src,
  output logic             err_multi,
  output logic             err_ovf
);

  localparam logic [SRC_W-1:0] SrcNone = SRC_W'(0);
  localparam logic [SRC_W-1:0] SrcAlu  = SRC_W'(1);
  localparam logic [SRC_W-1:0] SrcMul  = SRC_W'(2);
  localparam logic [SRC_W-1:0] SrcDiv  = SRC_W'(3);

  logic             alu_v, mul_v, div_v;
  logic             in_valid, in_multi;
  logic [XLEN-1:0]  in_r;
  logic [SRC_W-1:0] in_src;

  logic             acc_valid, k_valid;

  logic             ex_bubble_q, ex_bubble_d;
  logic [XLEN-1:0]  ex_r_q, ex_r_d;
  logic [SRC_W-1:0] ex_src_q, ex_src_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_r_q, skid_r_d;
  logic [SRC_W-1:0] skid_src_q, skid_src_d;
  logic             err_multi_q, err_multi_d;
  logic             err_ovf_q, err_ovf_d;

  assign alu_v    = ~alu_bubble;
  assign mul_v    = ~mul_bubble;
  assign div_v    = ~div_bubble;
  assign in_valid = alu_v | mul_v | div_v;
  assign in_multi = (alu_v & mul_v) | (alu_v & div_v) | (mul_v & div_v);

  // Priority MUL > DIV > ALU.
  always_comb begin
    in_r   = alu_r;
    in_src = SrcNone;
    if (mul_v) begin
      in_r   = mul_r;
      in_src = SrcMul;
    end else if (div_v) begin
      in_r   = div_r;
      in_src = SrcDiv;
    end else if (alu_v) begin
      in_r   = alu_r;
      in_src = SrcAlu;
    end
  end

  // Flush kills both the skid contents and anything arriving this cycle.
  assign acc_valid = in_valid & ~ex_flush;
  assign k_valid   = skid_valid_q & ~ex_flush;

  always_comb begin
    ex_bubble_d  = ex_bubble_q;
    ex_r_d       = ex_r_q;
    ex_src_d     = ex_src_q;
    skid_valid_d = k_valid;
    skid_r_d     = skid_r_q;
    skid_src_d   = skid_src_q;
    err_multi_d  = err_multi_q | in_multi;
    err_ovf_d    = err_ovf_q;

    if (!mem_stall) begin
      if (k_valid) begin
        ex_bubble_d  = 1'b0;
        ex_r_d       = skid_r_q;
        ex_src_d     = skid_src_q;
        skid_valid_d = acc_valid;
        if (acc_valid) begin
          skid_r_d   = in_r;
          skid_src_d = in_src;
        end
      end else begin
        ex_bubble_d  = ~acc_valid;
        ex_src_d     = acc_valid ? in_src : SrcNone;
        skid_valid_d = 1'b0;
        if (acc_valid) begin
          ex_r_d = in_r;
        end
      end
    end else if (acc_valid) begin
      if (!k_valid) begin
        skid_valid_d = 1'b1;
        skid_r_d     = in_r;
        skid_src_d   = in_src;
      end else begin
        err_ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_bubble_q  <= 1'b1;
      ex_r_q       <= '0;
      ex_src_q     <= SrcNone;
      skid_valid_q <= 1'b0;
      skid_r_q     <= '0;
      skid_src_q   <= SrcNone;
      err_multi_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      ex_bubble_q  <= ex_bubble_d;
      ex_r_q       <= ex_r_d;
      ex_src_q     <= ex_src_d;
      skid_valid_q <= skid_valid_d;
      skid_r_q     <= skid_r_d;
      skid_src_q   <= skid_src_d;
      err_multi_q  <= err_multi_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign ex_stall  = mem_stall | skid_valid_q;
  assign ex_bubble = ex_bubble_q;
  assign ex_r      = ex_r_q;
  assign ex_src    = ex_src_q;
  assign err_multi = err_multi_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_riscv_ex_result.sv
// Table-driven bench for riscv_ex_result; expected outputs flow through a scoreboard queue.
module tb_riscv_ex_result;

  typedef struct {
    logic        mv;
    logic [31:0] mr;
    logic        dv;
    logic [31:0] dr;
    logic        av;
    logic [31:0] ar;
    logic        fl;
    logic        ms;
    logic        eb;
    logic [31:0] er;
    logic [1:0]  es;
    logic        est;
    logic        emul;
    logic        eovf;
  } vec_t;

  typedef struct {
    logic        eb;
    logic [31:0] er;
    logic [1:0]  es;
    logic        est;
    logic        emul;
    logic        eovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alu_bubble, mul_bubble, div_bubble;
  logic [31:0] alu_r, mul_r, div_r;
  logic        ex_flush, mem_stall;
  logic        ex_stall, ex_bubble, err_multi, err_ovf;
  logic [31:0] ex_r;
  logic [1:0]  ex_src;

  int n_checks = 0;
  int n_fails  = 0;

  vec_t vecs[25];
  exp_t sb[$];

  riscv_ex_result #(
    .XLEN (32),
    .SRC_W(2)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .alu_bubble(alu_bubble),
    .alu_r     (alu_r),
    .mul_bubble(mul_bubble),
    .mul_r     (mul_r),
    .div_bubble(div_bubble),
    .div_r     (div_r),
    .ex_flush  (ex_flush),
    .mem_stall (mem_stall),
    .ex_stall  (ex_stall),
    .ex_bubble (ex_bubble),
    .ex_r      (ex_r),
    .ex_src    (ex_src),
    .err_multi (err_multi),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic mv, logic [31:0] mr, logic dv, logic [31:0] dr,
                             logic av, logic [31:0] ar, logic fl, logic ms,
                             logic eb, logic [31:0] er, logic [1:0] es, logic est,
                             logic emul, logic eovf);
    vec_t t;
    t.mv = mv; t.mr = mr; t.dv = dv; t.dr = dr; t.av = av; t.ar = ar;
    t.fl = fl; t.ms = ms; t.eb = eb; t.er = er; t.es = es; t.est = est;
    t.emul = emul; t.eovf = eovf;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " ex_bubble"}, 32'(ex_bubble), 32'(e.eb));
    check({tag, " ex_r"},      ex_r,           e.er);
    check({tag, " ex_src"},    32'(ex_src),    32'(e.es));
    check({tag, " ex_stall"},  32'(ex_stall),  32'(e.est));
    check({tag, " err_multi"}, 32'(err_multi), 32'(e.emul));
    check({tag, " err_ovf"},   32'(err_ovf),   32'(e.eovf));
  endtask

  task automatic idle_inputs();
    mul_bubble = 1'b1; div_bubble = 1'b1; alu_bubble = 1'b1;
    mul_r = $urandom; div_r = $urandom; alu_r = $urandom;
    ex_flush = 1'b0; mem_stall = 1'b0;
  endtask

  initial begin
    exp_t e;
    //             mv mr         dv dr         av ar         fl ms  eb er         es est mu ov
    vecs[0]  = v(0, 0,         0, 0,         1, 32'h11,    0, 0,  0, 32'h11,    1, 0, 0, 0);
    vecs[1]  = v(1, 32'h22,    0, 0,         0, 0,         0, 0,  0, 32'h22,    2, 0, 0, 0);
    vecs[2]  = v(0, 0,         0, 0,         0, 0,         0, 0,  1, 32'h22,    0, 0, 0, 0);
    vecs[3]  = v(0, 0,         0, 0,         1, 32'h11,    0, 0,  0, 32'h11,    1, 0, 0, 0);
    vecs[4]  = v(0, 0,         0, 0,         0, 0,         0, 1,  0, 32'h11,    1, 1, 0, 0);
    vecs[5]  = v(1, 32'hDEAD,  0, 0,         0, 0,         0, 1,  0, 32'h11,    1, 1, 0, 0);
    vecs[6]  = v(0, 0,         0, 0,         0, 0,         0, 1,  0, 32'h11,    1, 1, 0, 0);
    vecs[7]  = v(0, 0,         0, 0,         0, 0,         0, 1,  0, 32'h11,    1, 1, 0, 0);
    vecs[8]  = v(0, 0,         0, 0,         0, 0,         0, 0,  0, 32'hDEAD,  2, 0, 0, 0);
    vecs[9]  = v(0, 0,         0, 0,         0, 0,         0, 0,  1, 32'hDEAD,  0, 0, 0, 0);
    vecs[10] = v(0, 0,         0, 0,         1, 32'h33,    0, 1,  1, 32'hDEAD,  0, 1, 0, 0);
    vecs[11] = v(0, 0,         1, 32'h5,     0, 0,         0, 0,  0, 32'h33,    1, 1, 0, 0);
    vecs[12] = v(0, 0,         0, 0,         0, 0,         0, 0,  0, 32'h5,     3, 0, 0, 0);
    vecs[13] = v(0, 0,         0, 0,         0, 0,         0, 0,  1, 32'h5,     0, 0, 0, 0);
    vecs[14] = v(0, 0,         1, 32'h44,    0, 0,         0, 1,  1, 32'h5,     0, 1, 0, 0);
    vecs[15] = v(0, 0,         0, 0,         1, 32'h99,    0, 1,  1, 32'h5,     0, 1, 0, 1);
    vecs[16] = v(0, 0,         0, 0,         0, 0,         0, 0,  0, 32'h44,    3, 0, 0, 1);
    vecs[17] = v(0, 0,         0, 0,         0, 0,         0, 0,  1, 32'h44,    0, 0, 0, 1);
    vecs[18] = v(1, 32'h77,    0, 0,         1, 32'h88,    0, 0,  0, 32'h77,    2, 0, 1, 1);
    vecs[19] = v(0, 0,         0, 0,         0, 0,         0, 0,  1, 32'h77,    0, 0, 1, 1);
    vecs[20] = v(1, 32'hAA,    0, 0,         0, 0,         0, 1,  1, 32'h77,    0, 1, 1, 1);
    vecs[21] = v(0, 0,         1, 32'hBB,    0, 0,         1, 1,  1, 32'h77,    0, 1, 1, 1);
    vecs[22] = v(0, 0,         0, 0,         0, 0,         0, 0,  1, 32'h77,    0, 0, 1, 1);
    vecs[23] = v(0, 0,         0, 0,         1, 32'hCC,    1, 0,  1, 32'h77,    0, 0, 1, 1);
    vecs[24] = v(0, 0,         0, 0,         1, 32'hCD,    0, 0,  0, 32'hCD,    1, 0, 1, 1);

    // Reset state
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    e = '{eb: 1'b1, er: 32'h0, es: 2'd0, est: 1'b0, emul: 1'b0, eovf: 1'b0};
    check_all("reset", e);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      mul_bubble = ~vecs[i].mv; mul_r = vecs[i].mv ? vecs[i].mr : $urandom;
      div_bubble = ~vecs[i].dv; div_r = vecs[i].dv ? vecs[i].dr : $urandom;
      alu_bubble = ~vecs[i].av; alu_r = vecs[i].av ? vecs[i].ar : $urandom;
      ex_flush   = vecs[i].fl;
      mem_stall  = vecs[i].ms;
      sb.push_back('{eb: vecs[i].eb, er: vecs[i].er, es: vecs[i].es, est: vecs[i].est,
                     emul: vecs[i].emul, eovf: vecs[i].eovf});
      @(negedge clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL scoreboard: queue empty at vector %0d", i);
      end else begin
        e = sb.pop_front();
        check_all($sformatf("vec%0d", i), e);
      end
    end

    // Asynchronous reset while the skid holds a result
    idle_inputs();
    mem_stall  = 1'b1;
    mul_bubble = 1'b0;
    mul_r      = 32'hEE;
    @(negedge clk);
    mul_bubble = 1'b1;
    check("pre-reset ex_stall", 32'(ex_stall), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("async ex_bubble", 32'(ex_bubble), 32'd1);
    check("async ex_r", ex_r, 32'h0);
    check("async ex_src", 32'(ex_src), 32'd0);
    check("async ex_stall follows mem_stall", 32'(ex_stall), 32'd1);
    mem_stall = 1'b0;
    #1;
    check("async skid cleared", 32'(ex_stall), 32'd0);
    check("async err_multi", 32'(err_multi), 32'd0);
    check("async err_ovf", 32'(err_ovf), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post-reset no skid replay", 32'(ex_bubble), 32'd1);
    check("post-reset ex_r", ex_r, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
